// File: rtl/dso_pkg.sv
// Shared types and constants for the DSO digital core command path.
// Holds the framer FSM encodings, response codes and host opcodes.
package dso_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GOT1,
    GOT2
  } rx_state_e;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_e;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  localparam logic [7:0] DUMP_CH  = 8'h01;
  localparam logic [7:0] CFG_GAIN = 8'h02;
  localparam logic [7:0] TRIG_LVL = 8'h03;
  localparam logic [7:0] TRIG_POS = 8'h04;
  localparam logic [7:0] SET_DEC  = 8'h05;
  localparam logic [7:0] TRIG_CFG = 8'h06;
  localparam logic [7:0] CAL_OFF  = 8'h07;
  localparam logic [7:0] EEP_WR   = 8'h08;
  localparam logic [7:0] EEP_RD   = 8'h09;

  function automatic logic [23:0] pack_cmd(
    input logic [15:0] hi,
    input logic [7:0]  lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/dig_cmd_framer_if.sv
// UART-side, dispatcher-side and transmitter-side signals of the framer.
// master = framer, slave = surrounding UART/dispatcher logic.
interface dig_cmd_framer_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;

  modport master (
    input  rx_data, rx_rdy, clr_cmd_rdy,
    input  resp, send_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy,
    output tx_data, trmt, resp_sent, frame_err
  );

  modport slave (
    output rx_data, rx_rdy, clr_cmd_rdy,
    output resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy,
    input  tx_data, trmt, resp_sent, frame_err
  );
endinterface

// File: rtl/dig_cmd_framer_frame_timer.sv
// Saturating inter-byte idle counter; expired while enabled at the limit.
// Only instantiated when CMD_TIMEOUT_EN is defined.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && cnt_q != LIMIT) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LIMIT);

endmodule

// File: rtl/dig_cmd_framer.sv
// Three-byte UART command framer with single-byte response return path.
// Define CMD_TIMEOUT_EN to resync framing after TIMEOUT_CYC idle cycles.
module dig_cmd_framer
  import dso_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  dig_cmd_framer_if.master bus
);

  rx_state_e   rx_state_q, rx_state_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] hold_q, hold_d;
  logic [23:0] cmd_q, cmd_d;
  logic        set_pend_q, set_pend_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        clr_q, clr_d;
  logic        mask_q, mask_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        trmt_q, trmt_d;
  logic        sent_q, sent_d;
  logic        accept;
  logic        timeout;

  // receiver keeps rdy up through the pulse and one cycle after it
  assign accept = bus.rx_rdy && !clr_q && !mask_q;

`ifdef CMD_TIMEOUT_EN
  logic tmr_en;
  logic tmr_clr;

  assign tmr_en  = (rx_state_q != IDLE);
  assign tmr_clr = accept || !tmr_en;

  frame_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (timeout)
  );
`else
  logic unused_cfg;

  assign unused_cfg = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    rx_state_d = rx_state_q;
    hold_d     = hold_q;
    cmd_d      = cmd_q;
    set_pend_d = 1'b0;
    clr_d      = 1'b0;
    mask_d     = clr_q;
    ferr_d     = 1'b0;
    cmd_rdy_d  = cmd_rdy_q;
    if (set_pend_q) begin
      cmd_rdy_d = 1'b1;
    end else if (bus.clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end
    if (accept) begin
      clr_d = 1'b1;
      unique case (rx_state_q)
        IDLE: begin
          hold_d[15:8] = bus.rx_data;
          rx_state_d   = GOT1;
        end
        GOT1: begin
          hold_d[7:0] = bus.rx_data;
          rx_state_d  = GOT2;
        end
        GOT2: begin
          cmd_d      = pack_cmd(hold_q, bus.rx_data);
          set_pend_d = 1'b1;
          rx_state_d = IDLE;
          ferr_d     = (cmd_rdy_q || set_pend_q)
                       && !bus.clr_cmd_rdy;
        end
        default: rx_state_d = IDLE;
      endcase
    end else if (timeout) begin
      rx_state_d = IDLE;
      hold_d     = '0;
      ferr_d     = 1'b1;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    trmt_d     = 1'b0;
    sent_d     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (bus.send_resp) begin
          tx_data_d  = bus.resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (bus.tx_done) begin
          sent_d     = 1'b1;
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= IDLE;
      tx_state_q <= TX_IDLE;
      hold_q     <= '0;
      cmd_q      <= '0;
      set_pend_q <= 1'b0;
      cmd_rdy_q  <= 1'b0;
      clr_q      <= 1'b0;
      mask_q     <= 1'b0;
      ferr_q     <= 1'b0;
      tx_data_q  <= '0;
      trmt_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      hold_q     <= hold_d;
      cmd_q      <= cmd_d;
      set_pend_q <= set_pend_d;
      cmd_rdy_q  <= cmd_rdy_d;
      clr_q      <= clr_d;
      mask_q     <= mask_d;
      ferr_q     <= ferr_d;
      tx_data_q  <= tx_data_d;
      trmt_q     <= trmt_d;
      sent_q     <= sent_d;
    end
  end

  assign bus.clr_rx_rdy = clr_q;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;
  assign bus.frame_err  = ferr_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.trmt       = trmt_q;
  assign bus.resp_sent  = sent_q;

endmodule
